uart_frame_decoder: RTL
=======================

# uart_frame_decoder

Parses the ASCII status frames a host streams over the UART RX byte interface and drives the 16 LED bits and the 12 seven-segment element bits. It sits between the `uart` receiver (`rx_data`/`rx_valid`) and the board-side LED/display pins. It is the decode-side counterpart of the frame generator that serialises LED/element state to the host. Frames are `L` + 4 hex digits + LF for LEDs, and `E` + 3 hex digits + LF for elements.

## Interface
Parameters:
- DATA_WIDTH, 8: RX byte width.
- LED_COUNT, 16: LED register width; the L frame carries LED_COUNT/4 hex digits.
- ELEMENT_COUNT, 12: element register width; the E frame carries ELEMENT_COUNT/4 hex digits.
- TIMEOUT_CYCLES, 500_000: inter-byte timeout, used only with the timeout feature.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  block enable; when low, no byte is accepted and state holds.
- rx_data  input  DATA_WIDTH  received byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  decoder can accept a byte.
- led_data  output  LED_COUNT  decoded LED state.
- element_data  output  ELEMENT_COUNT  decoded segment/anode state (active-low).
- led_update  output  1  one-cycle pulse when led_data is loaded.
- element_update  output  1  one-cycle pulse when element_data is loaded.
- frame_error  output  1  one-cycle pulse when a frame is aborted.

## Operation
- Handshake:
  - rx_ready = ena.
  - A byte is accepted on a rising clk edge where rx_valid && rx_ready.
  - The decoder never back-pressures while enabled.
- CR (0x0D) is discarded in every state: no state change and no timeout restart, except as noted under Configuration.
- States:
  - IDLE: on 'L'/'l', set kind=LED, clear the accumulator and digit count, go to DIGITS. On 'E'/'e', do the same with kind=ELEM. Any other byte is dropped silently, with no error.
  - DIGITS: on a hex char ('0'-'9', 'A'-'F', 'a'-'f'), shift the nibble into the accumulator at the LSB end: acc = {acc[11:0], nib}. Increment the count. When the count reaches the needed digits (4 for LED, 3 for ELEM), go to TERM.
  - TERM: on LF (0x0A), commit acc to the target register and go to IDLE.
- Errors in DIGITS or TERM: any other byte pulses frame_error.
  - If the offending byte is 'L'/'l'/'E'/'e', the decoder restarts directly into DIGITS for that kind (resync).
  - Otherwise it goes to IDLE.
  - The target register is never partially updated.
- Width rules:
  - The accumulator is 16 bits.
  - An ELEM commit loads acc[11:0].
  - Digits are sent MSB nibble first.

## Timing
- Reset values:
  - led_data = 0, element_data = 12'hFFF (all segments/anodes off).
  - All pulses = 0; state = IDLE; accumulator and count = 0.
  - rx_ready follows ena immediately (combinational).
- Commit latency: the LF accepted at edge N makes led_data/element_data and the matching update pulse visible after edge N, for exactly one cycle of pulse.
- frame_error is asserted in the cycle after the offending byte is accepted, for one cycle.
- Back-to-back bytes on consecutive cycles are fully supported. Throughput is one byte per cycle.
- ena low mid-frame: state, accumulator and timeout counter all freeze. Decoding resumes when ena is high again.
- rst_n asserted mid-frame: immediate return to reset values. The partial frame is discarded with no error pulse.

## Configuration
- `UART_FRAME_DECODER_TIMEOUT_EN` defined:
  - In DIGITS or TERM, a counter increments each enabled cycle without an accepted byte. Any accepted byte, including CR, clears it.
  - Reaching TIMEOUT_CYCLES-1 pulses frame_error and returns to IDLE.
  - The counter width is $clog2(TIMEOUT_CYCLES).
- Undefined: no counter is instantiated, and a partial frame waits indefinitely.

## Structure
- Package `uart_frame_pkg`:
  - state enum (IDLE, DIGITS, TERM) and kind enum (LED, ELEM);
  - character constants CH_L, CH_E, CH_LF, CH_CR;
  - digit-count constants LED_DIGITS and ELEM_DIGITS.
- Sub-module `hex_ascii_decode`: combinational; byte in, 4-bit nibble and is_hex out. It is reusable by the switch-frame parser.

## Test plan
- Stream "L00A5\n" -> led_data = 16'h00A5, and led_update pulses once, one cycle after LF. element_data stays at 12'hFFF.
- Stream "e7f0\r\n" back-to-back (one byte/cycle) -> element_data = 12'h7F0 with one element_update pulse. The CR is ignored.
- Stream "L12G" then "L3456\n" -> frame_error pulses after 'G' and led_data is unchanged; then led_data = 16'h3456.
- Stream "L1234L5678\n" -> one frame_error on the second 'L' (resync), then led_data = 16'h5678.
- With `UART_FRAME_DECODER_TIMEOUT_EN` and TIMEOUT_CYCLES = 16: send "E12" then idle 20 cycles -> frame_error, state back to IDLE. A following "\n" produces no update.
- Reset: assert rst_n mid-frame "L98" -> outputs return to reset values with no error pulse. After release, "LFFFF\n" -> led_data = 16'hFFFF.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types and character constants for the UART status-frame decoder.
package uart_frame_pkg;

  typedef enum logic [1:0] {IDLE, DIGITS, TERM} state_t;
  typedef enum logic {LED, ELEM} kind_t;

  localparam logic [7:0] CH_L    = 8'h4C;
  localparam logic [7:0] CH_L_LC = 8'h6C;
  localparam logic [7:0] CH_E    = 8'h45;
  localparam logic [7:0] CH_E_LC = 8'h65;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_CR   = 8'h0D;

  localparam logic [2:0] LED_DIGITS  = 3'd4;
  localparam logic [2:0] ELEM_DIGITS = 3'd3;

  function automatic logic is_start(input logic [7:0] b);
    return (b == CH_L) || (b == CH_L_LC) || (b == CH_E) || (b == CH_E_LC);
  endfunction

  function automatic kind_t start_kind(input logic [7:0] b);
    return ((b == CH_L) || (b == CH_L_LC)) ? LED : ELEM;
  endfunction

endpackage

// File: rtl/hex_ascii_decode.sv
// Combinational ASCII hex character to nibble decoder.
module hex_ascii_decode (
  input  logic [7:0] ch,
  output logic [3:0] nib,
  output logic       is_hex
);

  // Letters A-F/a-f carry 1..6 in their low nibble, so +9 yields 10..15.
  always_comb begin
    nib    = '0;
    is_hex = 1'b0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      nib    = ch[3:0];
      is_hex = 1'b1;
    end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
      nib    = ch[3:0] + 4'd9;
      is_hex = 1'b1;
    end
  end

endmodule

// File: rtl/uart_frame_decoder.sv
// Decodes "L"+hex4+LF and "E"+hex3+LF status frames into LED/element registers.
// Optional inter-byte timeout: define UART_FRAME_DECODER_TIMEOUT_EN.
module uart_frame_decoder
  import uart_frame_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned LED_COUNT      = 16,
  parameter int unsigned ELEMENT_COUNT  = 12,
  parameter int unsigned TIMEOUT_CYCLES = 500_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [DATA_WIDTH-1:0]    rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic [LED_COUNT-1:0]     led_data,
  output logic [ELEMENT_COUNT-1:0] element_data,
  output logic                     led_update,
  output logic                     element_update,
  output logic                     frame_error
);

  localparam int unsigned ACC_W = 16;

  state_t                   state, state_n;
  kind_t                    kind, kind_n;
  logic [ACC_W-1:0]         acc, acc_n;
  logic [2:0]               cnt, cnt_n, cnt_inc, need;
  logic [LED_COUNT-1:0]     led_n;
  logic [ELEMENT_COUNT-1:0] elem_n;
  logic                     led_upd_n, elem_upd_n, err_n;
  logic                     accept, bad;
  logic [7:0]               ch;
  logic [3:0]               nib;
  logic                     is_hex;

`ifdef UART_FRAME_DECODER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo, tmo_n;
`endif

  assign rx_ready = ena;
  assign accept   = rx_valid && ena;
  assign ch       = rx_data[7:0];
  assign cnt_inc  = cnt + 3'd1;
  assign need     = (kind == LED) ? LED_DIGITS : ELEM_DIGITS;

  hex_ascii_decode u_hex (
    .ch     (ch),
    .nib    (nib),
    .is_hex (is_hex)
  );

  always_comb begin
    state_n    = state;
    kind_n     = kind;
    acc_n      = acc;
    cnt_n      = cnt;
    led_n      = led_data;
    elem_n     = element_data;
    led_upd_n  = 1'b0;
    elem_upd_n = 1'b0;
    err_n      = 1'b0;
    bad        = 1'b0;
`ifdef UART_FRAME_DECODER_TIMEOUT_EN
    tmo_n      = tmo;
`endif

    if (accept && ch != CH_CR) begin
      unique case (state)
        IDLE: begin
          if (is_start(ch)) begin
            kind_n  = start_kind(ch);
            acc_n   = '0;
            cnt_n   = '0;
            state_n = DIGITS;
          end
        end
        DIGITS: begin
          if (is_hex) begin
            acc_n = {acc[ACC_W-5:0], nib};
            cnt_n = cnt_inc;
            if (cnt_inc == need) state_n = TERM;
          end else begin
            bad = 1'b1;
          end
        end
        TERM: begin
          if (ch == CH_LF) begin
            state_n = IDLE;
            if (kind == LED) begin
              led_n     = acc[LED_COUNT-1:0];
              led_upd_n = 1'b1;
            end else begin
              elem_n     = acc[ELEMENT_COUNT-1:0];
              elem_upd_n = 1'b1;
            end
          end else begin
            bad = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase

      // A start character that breaks a frame opens the next one directly.
      if (bad) begin
        err_n = 1'b1;
        if (is_start(ch)) begin
          kind_n  = start_kind(ch);
          acc_n   = '0;
          cnt_n   = '0;
          state_n = DIGITS;
        end else begin
          state_n = IDLE;
        end
      end
    end

`ifdef UART_FRAME_DECODER_TIMEOUT_EN
    if (state == IDLE || accept) begin
      tmo_n = '0;
    end else if (ena) begin
      if (tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        err_n   = 1'b1;
        state_n = IDLE;
        tmo_n   = '0;
      end else begin
        tmo_n = tmo + TMO_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      kind           <= LED;
      acc            <= '0;
      cnt            <= '0;
      led_data       <= '0;
      element_data   <= '1;
      led_update     <= 1'b0;
      element_update <= 1'b0;
      frame_error    <= 1'b0;
`ifdef UART_FRAME_DECODER_TIMEOUT_EN
      tmo            <= '0;
`endif
    end else begin
      state          <= state_n;
      kind           <= kind_n;
      acc            <= acc_n;
      cnt            <= cnt_n;
      led_data       <= led_n;
      element_data   <= elem_n;
      led_update     <= led_upd_n;
      element_update <= elem_upd_n;
      frame_error    <= err_n;
`ifdef UART_FRAME_DECODER_TIMEOUT_EN
      tmo            <= tmo_n;
`endif
    end
  end

endmodule
